div_meas: RTL and testbench

//  Receive-side companion of the programmable clock divider. Samples a divided

---
 rtl/div_meas.sv | 135 +++++++++++++
 tb/tb_div_meas.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/div_meas.sv
// Period / high-time meter for a slow signal sampled in the clk domain.
// Reports each complete period and flags a missing edge after MAX cycles.
module div_meas #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  input  logic         EN,
  input  logic [W-1:0] Din,
  output logic [W-1:0] PERIOD,
  output logic [W-1:0] HIGH,
  output logic         VALID,
  output logic         MATCH,
  output logic         TIMEOUT
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TOVER
  } state_t;

  state_t state, state_d;

  logic s1, s2, s3;
  logic rise;

  logic [W-1:0] cnt, cnt_d;
  logic [W-1:0] hcnt, hcnt_d;
  logic [W-1:0] period_d, high_d;
  logic         valid_d, match_d, timeout_d;

  // s1/s2 resolve metastability, s3 delays s2 for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hcnt    <= '0;
      PERIOD  <= '0;
      HIGH    <= '0;
      VALID   <= 1'b0;
      MATCH   <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      hcnt    <= hcnt_d;
      PERIOD  <= period_d;
      HIGH    <= high_d;
      VALID   <= valid_d;
      MATCH   <= match_d;
      TIMEOUT <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hcnt_d    = hcnt;
    period_d  = PERIOD;
    high_d    = HIGH;
    valid_d   = 1'b0;
    match_d   = MATCH;
    timeout_d = TIMEOUT;
    if (!EN) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_d  = '0;
          hcnt_d = '0;
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = ONE;
            hcnt_d  = ONE;
          end
        end
        MEASURE: begin
          // a rise at cnt==MAX still closes a valid period
          if (rise) begin
            period_d  = cnt;
            high_d    = hcnt;
            match_d   = (cnt == Din);
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = ONE;
            hcnt_d    = ONE;
          end else if (cnt == MAX) begin
            state_d   = TOVER;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt + ONE;
            if (s2) begin
              hcnt_d = hcnt + ONE;
            end
          end
        end
        TOVER: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = ONE;
            hcnt_d  = ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_meas.sv
// Directed bench for div_meas at W=4 so saturation is reachable quickly.
// Each rise is reported two clocks later and describes the previous period.
module tb_div_meas;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sig_in = 1'b0;
  logic         EN = 1'b0;
  logic [W-1:0] Din = '0;
  logic [W-1:0] PERIOD, HIGH;
  logic         VALID, MATCH, TIMEOUT;

  int nvec = 0;
  int nerr = 0;
  int nv = 0;
  int dbl = 0;
  logic lastv = 1'b0;
  logic [31:0] cp, ch, cm, ct;

  div_meas #(.W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .EN(EN),
    .Din(Din),
    .PERIOD(PERIOD),
    .HIGH(HIGH),
    .VALID(VALID),
    .MATCH(MATCH),
    .TIMEOUT(TIMEOUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic steps(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = v;
      @(posedge clk);
      #1;
      if (VALID && lastv) dbl++;
      lastv = VALID;
      if (VALID) begin
        nv++;
        cp = 32'(PERIOD);
        ch = 32'(HIGH);
        cm = 32'(MATCH);
        ct = 32'(TIMEOUT);
      end
    end
  endtask

  task automatic run_period(input int h, input int l);
    nv = 0;
    steps(1'b1, h);
    steps(1'b0, l);
  endtask

  initial begin
    cp = '0; ch = '0; cm = '0; ct = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_period", 32'(PERIOD), 0);
    check("rst_high", 32'(HIGH), 0);
    check("rst_valid", 32'(VALID), 0);
    check("rst_match", 32'(MATCH), 0);
    check("rst_timeout", 32'(TIMEOUT), 0);
    @(negedge clk);
    rst_n = 1'b1;
    steps(1'b0, 4);

    // P=4, H=2, Din=4
    EN = 1'b1;
    Din = 4'd4;
    run_period(2, 2);
    check("t1_arm_novalid", 32'(nv), 0);
    for (int k = 0; k < 3; k++) begin
      run_period(2, 2);
      check("t1_nvalid", 32'(nv), 1);
      check("t1_period", cp, 4);
      check("t1_high", ch, 2);
      check("t1_match", cm, 1);
    end

    // P=6, H=3 against Din=4, then Din=6
    run_period(3, 3);
    check("t2_trans_period", cp, 4);
    run_period(3, 3);
    check("t2_period", cp, 6);
    check("t2_high", ch, 3);
    check("t2_match", cm, 0);
    Din = 4'd6;
    run_period(3, 3);
    check("t2_match_din6", cm, 1);

    // duty 1/5
    Din = 4'd5;
    run_period(1, 4);
    check("t3_trans_period", cp, 6);
    run_period(1, 4);
    check("t3_period", cp, 5);
    check("t3_high", ch, 1);
    check("t3_match", cm, 1);

    // period exactly MAX: rise wins over saturation
    run_period(1, 14);
    check("sat_trans_period", cp, 5);
    run_period(1, 14);
    check("sat_nvalid", 32'(nv), 1);
    check("sat_period", cp, 15);
    check("sat_high", ch, 1);
    check("sat_timeout", ct, 0);
    check("sat_match", cm, 0);

    // held low after a rise: timeout on the 15th count
    nv = 0;
    steps(1'b1, 1);
    steps(1'b0, 2);
    check("to_last_valid", 32'(VALID), 1);
    check("to_last_period", 32'(PERIOD), 15);
    nv = 0;
    steps(1'b0, 14);
    check("to_not_yet", 32'(TIMEOUT), 0);
    steps(1'b0, 1);
    check("to_set", 32'(TIMEOUT), 1);
    steps(1'b0, 5);
    check("to_novalid", 32'(nv), 0);
    check("to_period_hold", 32'(PERIOD), 15);
    run_period(1, 4);
    check("to_rearm_novalid", 32'(nv), 0);
    check("to_rearm_sticky", 32'(TIMEOUT), 1);
    run_period(1, 4);
    check("to_recover_nvalid", 32'(nv), 1);
    check("to_recover_period", cp, 5);
    check("to_recover_timeout", ct, 0);
    check("to_recover_match", cm, 1);

    // EN low for one clk exactly when the rise is processed
    nv = 0;
    steps(1'b1, 1);
    steps(1'b0, 1);
    EN = 1'b0;
    steps(1'b0, 1);
    check("en_valid", 32'(VALID), 0);
    check("en_timeout", 32'(TIMEOUT), 0);
    check("en_period_hold", 32'(PERIOD), 5);
    EN = 1'b1;
    steps(1'b0, 2);
    check("en_nvalid", 32'(nv), 0);
    run_period(1, 4);
    check("en_arm_novalid", 32'(nv), 0);
    run_period(1, 4);
    check("en_nvalid2", 32'(nv), 1);
    check("en_period", cp, 5);
    check("en_high", ch, 1);

    // EN low clears a sticky timeout
    steps(1'b0, 20);
    check("en_to_set", 32'(TIMEOUT), 1);
    EN = 1'b0;
    steps(1'b0, 1);
    check("en_to_clear", 32'(TIMEOUT), 0);
    EN = 1'b1;

    // asynchronous reset in mid-period
    run_period(1, 4);
    run_period(3, 3);
    check("rs_pre_period", 32'(PERIOD), 5);
    steps(1'b1, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rs_period", 32'(PERIOD), 0);
    check("rs_high", 32'(HIGH), 0);
    check("rs_valid", 32'(VALID), 0);
    check("rs_match", 32'(MATCH), 0);
    check("rs_timeout", 32'(TIMEOUT), 0);
    sig_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    steps(1'b0, 3);
    run_period(2, 2);
    check("rs_arm_novalid", 32'(nv), 0);
    run_period(2, 2);
    check("rs_nvalid", 32'(nv), 1);
    check("rs_result_period", cp, 4);
    check("rs_result_high", ch, 2);

    check("no_back_to_back_valid", 32'(dbl), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
